// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN image readback path: image geometry and the
// transmit-packer state encoding.
package cnn_pkg;
  localparam int IMG_BITS  = 784;
  localparam int IMG_BYTES = IMG_BITS / 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    XMIT,
    WAIT_TX,
    FIN
  } state_t;
endpackage

// File: rtl/cnn_tx_packer.sv
// Reads a 1-bit-wide image RAM eight addresses at a time, packs each group
// LSB-first into a byte and hands it to a UART transmitter with a trmt pulse.
module cnn_tx_packer
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMG_BITS,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strt,
  input  logic          abort,
  output logic [AW-1:0] addr_rd,
  input  logic          din,
  output logic          trmt,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic          bsy,
  output logic          done
);
  localparam int            BCW       = AW - 3;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(DEPTH / 8 - 1);

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [3:0]     fcnt;     // FETCH cycle 0..8; cycle 8 only captures the last bit
  logic [2:0]     k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      fcnt     <= '0;
      tx_data  <= '0;
    end else if (abort && state != IDLE) begin
      state    <= IDLE;
      byte_cnt <= '0;
      fcnt     <= '0;
    end else begin
      case (state)
        IDLE: if (strt && !abort) begin
          state    <= FETCH;
          byte_cnt <= '0;
          fcnt     <= '0;
        end
        FETCH: begin
          // din lags addr_rd by one cycle, so cycle n captures bit n-1
          if (fcnt != 4'd0) tx_data[3'(fcnt - 4'd1)] <= din;
          if (fcnt == 4'd8) begin
            state <= XMIT;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        XMIT: state <= WAIT_TX;
        WAIT_TX: if (tx_done) begin
          if (byte_cnt == LAST_BYTE) begin
            state <= FIN;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= FETCH;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The latency cycle re-presents bit 7 so the address never leaves the byte.
  assign k       = fcnt[3] ? 3'd7 : fcnt[2:0];
  assign addr_rd = (state == FETCH) ? {byte_cnt, k} : '0;
  assign trmt    = (state == XMIT);
  assign done    = (state == FIN);
  assign bsy     = (state != IDLE);
endmodule

// File: tb/tb_cnn_tx_packer.sv
// Self-checking bench: behavioural RAM and UART responder, byte-level model of
// the expected frame computed straight from RAM contents.
module tb_cnn_tx_packer;
  import cnn_pkg::*;
  localparam int DEPTH = IMG_BITS;
  localparam int AW    = 10;
  localparam int NB    = IMG_BYTES;

  logic          clk = 1'b0, rst_n = 1'b0, strt = 1'b0, abort = 1'b0;
  logic          din = 1'b0, tx_done = 1'b0;
  logic [AW-1:0] addr_rd;
  logic          trmt, bsy, done;
  logic [7:0]    tx_data;

  cnn_tx_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .abort(abort), .addr_rd(addr_rd),
    .din(din), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .bsy(bsy), .done(done)
  );

  always #5 clk = ~clk;

  logic ram [DEPTH];
  always @(posedge clk) din <= (int'(addr_rd) < DEPTH) ? ram[addr_rd] : 1'b0;

  // Monitor: records every transmitted byte with its cycle stamp.
  int         cyc = 0, done_cnt = 0, max_addr = 0, idle_bad = 0;
  logic [7:0] got_q[$];
  int         t_q[$];
  always @(negedge clk) begin
    cyc++;
    if (trmt) begin
      got_q.push_back(tx_data);
      t_q.push_back(cyc);
    end
    if (done) done_cnt++;
    if (strt) max_addr = 0;
    else if (int'(addr_rd) > max_addr) max_addr = int'(addr_rd);
    if (!bsy && (addr_rd != '0 || trmt || done)) idle_bad++;
  end

  // UART responder: tx_done pulses dly cycles after the trmt cycle.
  int dly = 1;
  initial forever begin
    @(negedge clk);
    if (trmt) begin
      @(posedge clk);
      repeat (dly - 1) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  int checks = 0, errors = 0;
  logic [7:0] fast_seq[$];

  function automatic logic [7:0] exp_byte(int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = ram[8*b + i];
    return v;
  endfunction

  task automatic fill_ram(input bit rnd);
    for (int i = 0; i < DEPTH; i++) ram[i] = rnd ? 1'($urandom) : 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 strt = 1'b1;
    @(posedge clk); #1 strt = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({addr_rd, tx_data, trmt, bsy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got addr=%0d data=%h trmt=%b bsy=%b done=%b want all 0",
               addr_rd, tx_data, trmt, bsy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zeros();
    int qb, db, bad, sp;
    bit ok;
    fill_ram(1'b0); dly = 1;
    qb = got_q.size(); db = done_cnt;
    start_frame();
    wait_done(db, 3000, ok);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL zeros_timeout got no done want done"); end
    checks++;
    if (got_q.size() - qb != NB) begin
      errors++; $display("FAIL zeros_count got %0d want %0d", got_q.size() - qb, NB);
    end
    bad = 0; sp = 0;
    for (int i = qb; i < got_q.size(); i++) begin
      if (got_q[i] !== 8'h00) bad++;
      if (i > qb && t_q[i] - t_q[i-1] != 11) sp++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL zeros_data got %0d nonzero bytes want 0", bad); end
    checks++;
    if (sp != 0) begin errors++; $display("FAIL zeros_spacing got %0d gaps != 11 want 0", sp); end
    checks++;
    if (done_cnt - db != 1) begin
      errors++; $display("FAIL zeros_done got %0d pulses want 1", done_cnt - db);
    end
    checks++;
    if (max_addr != DEPTH - 1) begin
      errors++; $display("FAIL zeros_max_addr got %0d want %0d", max_addr, DEPTH - 1);
    end
  endtask

  task automatic test_pattern();
    int qb, db, bad, sp;
    bit ok;
    logic [7:0] pat;
    fill_ram(1'b1); dly = 1;
    pat = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin ram[i] = pat[i]; ram[8+i] = 1'b1; end
    qb = got_q.size(); db = done_cnt;
    start_frame();
    wait_done(db, 3000, ok);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (!ok || got_q.size() - qb != NB) begin
      errors++; $display("FAIL pattern_count got %0d bytes want %0d", got_q.size() - qb, NB);
    end else begin
      checks++;
      if (got_q[qb] !== 8'hA5) begin
        errors++; $display("FAIL pattern_byte0 got %h want a5", got_q[qb]);
      end
      checks++;
      if (got_q[qb+1] !== 8'hFF) begin
        errors++; $display("FAIL pattern_byte1 got %h want ff", got_q[qb+1]);
      end
      bad = 0; sp = 0;
      fast_seq.delete();
      for (int i = 0; i < NB; i++) begin
        fast_seq.push_back(got_q[qb+i]);
        if (got_q[qb+i] !== exp_byte(i)) bad++;
        if (i > 0 && t_q[qb+i] - t_q[qb+i-1] != 11) sp++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL pattern_model got %0d wrong bytes want 0", bad); end
      checks++;
      if (sp != 0) begin errors++; $display("FAIL pattern_spacing got %0d gaps != 11 want 0", sp); end
    end
  endtask

  task automatic test_slow();
    int qb, db, bad, sp;
    bit ok;
    dly = 200;
    qb = got_q.size(); db = done_cnt;
    start_frame();
    wait_done(db, NB * 215 + 200, ok);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (!ok || got_q.size() - qb != NB || fast_seq.size() != NB) begin
      errors++; $display("FAIL slow_count got %0d bytes want %0d", got_q.size() - qb, NB);
    end else begin
      bad = 0; sp = 0;
      for (int i = 0; i < NB; i++) begin
        if (got_q[qb+i] !== fast_seq[i] || got_q[qb+i] !== exp_byte(i)) bad++;
        if (i > 0 && t_q[qb+i] - t_q[qb+i-1] != 210) sp++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL slow_sequence got %0d differing bytes want 0", bad); end
      checks++;
      if (sp != 0) begin errors++; $display("FAIL slow_spacing got %0d gaps != 210 want 0", sp); end
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++; $display("FAIL slow_done got %0d pulses want 1", done_cnt - db);
    end
    dly = 1;
  endtask

  task automatic test_abort();
    int qb, db, bad;
    bit ok;
    fill_ram(1'b1); dly = 3;
    qb = got_q.size(); db = done_cnt;
    start_frame();
    wait_bytes(qb + 6, 500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach got %0d bytes want 6", got_q.size() - qb); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++;
    if (bsy !== 1'b0 || trmt !== 1'b0) begin
      errors++; $display("FAIL abort_idle got bsy=%b trmt=%b want 0 0", bsy, trmt);
    end
    repeat (300) @(posedge clk); #1;
    checks++;
    if (got_q.size() - qb != 6 || done_cnt != db) begin
      errors++; $display("FAIL abort_quiet got bytes=%0d done=%0d want 6 0",
                         got_q.size() - qb, done_cnt - db);
    end
    dly = 1;
    qb = got_q.size(); db = done_cnt;
    @(posedge clk); #1 strt = 1'b1;
    @(posedge clk); #1 strt = 1'b0;
    checks++;
    if (bsy !== 1'b1 || addr_rd !== 10'd0) begin
      errors++; $display("FAIL restart_addr0 got bsy=%b addr=%0d want 1 0", bsy, addr_rd);
    end
    @(posedge clk); #1;
    checks++;
    if (addr_rd !== 10'd1) begin errors++; $display("FAIL restart_addr1 got %0d want 1", addr_rd); end
    wait_done(db, 3000, ok);
    repeat (5) @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < NB && qb + i < got_q.size(); i++) if (got_q[qb+i] !== exp_byte(i)) bad++;
    checks++;
    if (!ok || got_q.size() - qb != NB || bad != 0) begin
      errors++; $display("FAIL restart_frame got bytes=%0d wrong=%0d want %0d 0",
                         got_q.size() - qb, bad, NB);
    end
  endtask

  task automatic test_strt_busy();
    int qb, db, bad;
    bit ok;
    fill_ram(1'b1); dly = 1;
    qb = got_q.size(); db = done_cnt;
    start_frame();
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(150, 20)) @(posedge clk);
      #1 strt = 1'b1;
      @(posedge clk); #1 strt = 1'b0;
    end
    wait_done(db, 3000, ok);
    repeat (50) @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < NB && qb + i < got_q.size(); i++) if (got_q[qb+i] !== exp_byte(i)) bad++;
    checks++;
    if (!ok || got_q.size() - qb != NB || bad != 0) begin
      errors++; $display("FAIL busy_strt_frame got bytes=%0d wrong=%0d want %0d 0",
                         got_q.size() - qb, bad, NB);
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++; $display("FAIL busy_strt_done got %0d pulses want 1", done_cnt - db);
    end
  endtask

  task automatic test_reset_mid();
    int qb, db;
    bit ok;
    fill_ram(1'b1); dly = 1;
    qb = got_q.size(); db = done_cnt;
    start_frame();
    wait_bytes(qb + 3, 500, ok);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (!ok || bsy !== 1'b1 || addr_rd !== 10'd25) begin
      errors++; $display("FAIL midreset_fetch got bsy=%b addr=%0d want 1 25", bsy, addr_rd);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_rd, tx_data, trmt, bsy, done} !== '0) begin
      errors++; $display("FAIL midreset_outputs got addr=%0d data=%h trmt=%b bsy=%b done=%b want all 0",
                         addr_rd, tx_data, trmt, bsy, done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (100) @(posedge clk); #1;
    checks++;
    if (got_q.size() - qb != 3 || done_cnt != db || bsy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet got bytes=%0d done=%0d bsy=%b want 3 0 0",
                         got_q.size() - qb, done_cnt - db, bsy);
    end
  endtask

  task automatic test_abort_idle();
    int qb;
    qb = got_q.size();
    @(posedge clk); #1 strt = 1'b1; abort = 1'b1;
    @(posedge clk); #1 strt = 1'b0; abort = 1'b0;
    checks++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL abort_strt_idle got bsy=%b want 0", bsy); end
    repeat (30) @(posedge clk); #1;
    checks++;
    if (got_q.size() != qb) begin
      errors++; $display("FAIL abort_strt_quiet got %0d bytes want 0", got_q.size() - qb);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_pattern();
    test_slow();
    test_abort();
    test_strt_busy();
    test_reset_mid();
    test_abort_idle();
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL idle_outputs got %0d bad idle cycles want 0", idle_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
